// File: rtl/boid_frame_scheduler.sv
// Per-frame boid display sequencer: swaps/clears the display RAM on
// end-of-screen, then walks every BPU and plots one pixel per boid.
module boid_frame_scheduler #(
  parameter int MAX_BOIDS    = 4,
  parameter int SEL_WIDTH    = 2,
  parameter int VIDEO_WIDTH  = 640,
  parameter int VIDEO_HEIGHT = 480,
  parameter int ADDR_WIDTH   = 19
) (
  input  logic                  clock,
  input  logic                  CPU_RESETN,
  input  logic                  enable,
  input  logic                  screen_end,
  input  logic [9:0]            boid_x,
  input  logic [8:0]            boid_y,
  input  logic                  overrun_clear,
  output logic [SEL_WIDTH-1:0]  boid_sel,
  output logic                  disp_swap,
  output logic                  disp_we,
  output logic [ADDR_WIDTH-1:0] disp_addr,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun,
  output logic [15:0]           frame_count,
  output logic [SEL_WIDTH:0]    skip_count
);

  typedef enum logic [2:0] {
    IDLE,
    SWAP,
    FETCH,
    WRITE,
    DONE
  } state_t;

  localparam logic [31:0] VW = 32'(VIDEO_WIDTH);
  localparam logic [31:0] VH = 32'(VIDEO_HEIGHT);
  localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(MAX_BOIDS - 1);

  state_t state;
  state_t state_nx;

  logic [9:0]            cap_x;
  logic [8:0]            cap_y;
  logic [SEL_WIDTH:0]    acc;
  logic [SEL_WIDTH:0]    acc_d;
  logic [SEL_WIDTH-1:0]  sel_d;
  logic                  swap_d;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  busy_d;
  logic                  done_d;
  logic                  ov_d;
  logic [15:0]           fc_d;
  logic [SEL_WIDTH:0]    sk_d;
  logic                  start;
  logic                  last;

  function automatic logic on_screen(input logic [9:0] x,
                                     input logic [8:0] y);
    return (32'(x) < VW) && (32'(y) < VH);
  endfunction

  assign start = (state == IDLE) && screen_end && enable;
  assign last  = (boid_sel == LAST);

  // State register
  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) state <= IDLE;
    else             state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SWAP;
      SWAP:    state_nx = FETCH;
      FETCH:   state_nx = WRITE;
      WRITE:   state_nx = last ? DONE : FETCH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values for the registered outputs and walk bookkeeping
  always_comb begin
    sel_d  = boid_sel;
    acc_d  = acc;
    we_d   = 1'b0;
    addr_d = disp_addr;
    fc_d   = frame_count;
    sk_d   = skip_count;
    swap_d = (state_nx == SWAP);
    done_d = (state_nx == DONE);
    busy_d = (state_nx != IDLE);
    unique case (state)
      IDLE: begin
        if (start) begin
          sel_d = '0;
          acc_d = '0;
        end
      end
      FETCH: begin
        if (on_screen(boid_x, boid_y)) begin
          we_d   = 1'b1;
          addr_d = ADDR_WIDTH'(32'(boid_y) * VW + 32'(boid_x));
        end
      end
      WRITE: begin
        if (!on_screen(cap_x, cap_y)) acc_d = acc + 1'b1;
        if (!last) sel_d = boid_sel + 1'b1;
      end
      DONE: begin
        fc_d = frame_count + 16'd1;
        sk_d = acc;
      end
      default: ;
    endcase
    if (screen_end && state != IDLE) ov_d = 1'b1;
    else if (overrun_clear)          ov_d = 1'b0;
    else                             ov_d = overrun;
  end

  // Output and datapath registers
  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      boid_sel    <= '0;
      disp_swap   <= 1'b0;
      disp_we     <= 1'b0;
      disp_addr   <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
      skip_count  <= '0;
      acc         <= '0;
      cap_x       <= '0;
      cap_y       <= '0;
    end else begin
      boid_sel    <= sel_d;
      disp_swap   <= swap_d;
      disp_we     <= we_d;
      disp_addr   <= addr_d;
      busy        <= busy_d;
      frame_done  <= done_d;
      overrun     <= ov_d;
      frame_count <= fc_d;
      skip_count  <= sk_d;
      acc         <= acc_d;
      if (state == FETCH) begin
        cap_x <= boid_x;
        cap_y <= boid_y;
      end
    end
  end

endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Scoreboard bench for boid_frame_scheduler: stimulus pushes expected
// swap/write/done events, a negedge monitor pops and compares them.
module tb_boid_frame_scheduler;

  localparam int M  = 4;
  localparam int SW = 2;
  localparam int AW = 19;

  logic          clock = 1'b0;
  logic          CPU_RESETN = 1'b0;
  logic          enable = 1'b1;
  logic          screen_end = 1'b0;
  logic          overrun_clear = 1'b0;
  logic [9:0]    boid_x;
  logic [8:0]    boid_y;
  logic [SW-1:0] boid_sel;
  logic          disp_swap;
  logic          disp_we;
  logic [AW-1:0] disp_addr;
  logic          busy;
  logic          frame_done;
  logic          overrun;
  logic [15:0]   frame_count;
  logic [SW:0]   skip_count;

  logic [9:0] bx [M];
  logic [8:0] by [M];

  assign boid_x = bx[boid_sel];
  assign boid_y = by[boid_sel];

  boid_frame_scheduler #(
    .MAX_BOIDS(M), .SEL_WIDTH(SW), .VIDEO_WIDTH(640),
    .VIDEO_HEIGHT(480), .ADDR_WIDTH(AW)
  ) dut (
    .clock(clock), .CPU_RESETN(CPU_RESETN), .enable(enable),
    .screen_end(screen_end), .boid_x(boid_x), .boid_y(boid_y),
    .overrun_clear(overrun_clear), .boid_sel(boid_sel),
    .disp_swap(disp_swap), .disp_we(disp_we), .disp_addr(disp_addr),
    .busy(busy), .frame_done(frame_done), .overrun(overrun),
    .frame_count(frame_count), .skip_count(skip_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
  } wr_t;

  typedef struct {
    int          c;
    logic [15:0] fc;
    logic [SW:0] sk;
  } dn_t;

  int   swq [$];
  wr_t  wrq [$];
  dn_t  dnq [$];
  int   busy_end = -100;
  logic [15:0] fc_m = '0;
  bit   ov_m = 1'b0;
  bit   pend = 1'b0;
  dn_t  pend_v;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d want %0d at cycle %0d", n, a, e, cyc);
    end
  endtask

  task automatic miss(input string n);
    checks++;
    errors++;
    $display("FAIL %s unexpected event at cycle %0d", n, cyc);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic wait_idle();
    wait_cyc(busy_end + 3);
  endtask

  task automatic flush();
    swq.delete();
    wrq.delete();
    dnq.delete();
    pend = 1'b0;
    busy_end = -100;
    fc_m = '0;
    ov_m = 1'b0;
  endtask

  task automatic start_walk(input int c);
    int  sk;
    wr_t w;
    dn_t d;
    sk = 0;
    swq.push_back(c + 1);
    for (int k = 0; k < M; k++) begin
      if (bx[k] < 10'd640 && by[k] < 9'd480) begin
        w.c = c + 3 + 2 * k;
        w.a = AW'(int'(by[k]) * 640 + int'(bx[k]));
        wrq.push_back(w);
      end else begin
        sk++;
      end
    end
    fc_m = fc_m + 16'd1;
    d.c  = c + 2 + 2 * M;
    d.fc = fc_m;
    d.sk = (SW+1)'(sk);
    dnq.push_back(d);
    busy_end = c + 2 + 2 * M;
  endtask

  task automatic fire(input bit en, input bit clr);
    int c;
    c = cyc;
    enable = en;
    screen_end = 1'b1;
    overrun_clear = clr;
    if (c <= busy_end) begin
      ov_m = 1'b1;
    end else begin
      if (clr) ov_m = 1'b0;
      if (en) start_walk(c);
    end
    tick();
    screen_end = 1'b0;
    overrun_clear = 1'b0;
    enable = 1'b1;
  endtask

  task automatic clear_ov();
    overrun_clear = 1'b1;
    ov_m = 1'b0;
    tick();
    overrun_clear = 1'b0;
  endtask

  task automatic set_pos(input int k, input int x, input int y);
    bx[k] = 10'(x);
    by[k] = 9'(y);
  endtask

  task automatic rand_pos();
    for (int k = 0; k < M; k++) begin
      case ($urandom_range(0, 5))
        0: set_pos(k, $urandom_range(640, 1023), $urandom_range(0, 511));
        1: set_pos(k, $urandom_range(0, 1023), $urandom_range(480, 511));
        2: set_pos(k, 639, 479);
        default: set_pos(k, $urandom_range(0, 639), $urandom_range(0, 479));
      endcase
    end
  endtask

  task automatic chk_all_zero(input string n);
    chk({n, "_swap"}, 32'(disp_swap), 0);
    chk({n, "_we"}, 32'(disp_we), 0);
    chk({n, "_addr"}, 32'(disp_addr), 0);
    chk({n, "_busy"}, 32'(busy), 0);
    chk({n, "_done"}, 32'(frame_done), 0);
    chk({n, "_overrun"}, 32'(overrun), 0);
    chk({n, "_fcount"}, 32'(frame_count), 0);
    chk({n, "_skip"}, 32'(skip_count), 0);
    chk({n, "_sel"}, 32'(boid_sel), 0);
  endtask

  // Monitor: compares DUT events against the scoreboard queues
  initial begin
    int  e;
    wr_t w;
    dn_t d;
    forever begin
      @(negedge clock);
      if (CPU_RESETN) begin
        if (pend) begin
          chk("frame_count", 32'(frame_count), 32'(pend_v.fc));
          chk("skip_count", 32'(skip_count), 32'(pend_v.sk));
          pend = 1'b0;
        end
        if (disp_swap) begin
          if (swq.size() == 0) miss("swap");
          else begin
            e = swq.pop_front();
            chk("swap_cycle", cyc, e);
            chk("swap_busy", 32'(busy), 1);
          end
        end
        if (disp_we) begin
          if (wrq.size() == 0) miss("write");
          else begin
            w = wrq.pop_front();
            chk("wr_cycle", cyc, w.c);
            chk("wr_addr", 32'(disp_addr), 32'(w.a));
          end
        end
        if (frame_done) begin
          if (dnq.size() == 0) miss("frame_done");
          else begin
            d = dnq.pop_front();
            chk("done_cycle", cyc, d.c);
            chk("done_busy", 32'(busy), 1);
            pend_v = d;
            pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int k = 0; k < M; k++) set_pos(k, 0, 0);
    CPU_RESETN = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    CPU_RESETN = 1'b1;
    tick();

    set_pos(0, 10, 10);
    set_pos(1, 0, 0);
    set_pos(2, 639, 479);
    set_pos(3, 100, 5);
    c = cyc;
    fire(1'b1, 1'b0);
    chk("basic_busy", 32'(busy), 1);
    wait_idle();
    chk("basic_idle", 32'(busy), 0);

    set_pos(1, 640, 0);
    set_pos(3, 5, 480);
    c = cyc;
    fire(1'b1, 1'b0);
    wait_cyc(c + 5);
    chk("off1_we", 32'(disp_we), 0);
    chk("off1_addr", 32'(disp_addr), 6410);
    wait_cyc(c + 9);
    chk("off3_we", 32'(disp_we), 0);
    chk("off3_addr", 32'(disp_addr), 307199);
    wait_idle();

    chk("ov_pre", 32'(overrun), 0);
    c = cyc;
    fire(1'b1, 1'b0);
    wait_cyc(c + 4);
    chk("ov_c4", 32'(overrun), 0);
    fire(1'b1, 1'b0);
    chk("ov_c5", 32'(overrun), 1);
    wait_cyc(c + 20);
    clear_ov();
    chk("ov_cleared", 32'(overrun), 0);
    c = cyc;
    fire(1'b1, 1'b0);
    wait_cyc(c + 4);
    fire(1'b1, 1'b1);
    chk("ov_set_wins", 32'(overrun), 1);
    wait_idle();
    clear_ov();
    c = cyc;
    fire(1'b1, 1'b0);
    wait_cyc(c + 2 + 2 * M);
    chk("done_state", 32'(frame_done), 1);
    fire(1'b1, 1'b0);
    chk("done_se_nostart", 32'(busy), 0);
    chk("done_se_overrun", 32'(overrun), 1);
    fire(1'b1, 1'b0);
    chk("after_done_start", 32'(busy), 1);
    wait_idle();

    c = cyc;
    fire(1'b1, 1'b0);
    wait_cyc(c + 6);
    CPU_RESETN = 1'b0;
    flush();
    #1;
    chk_all_zero("midreset");
    tick();
    CPU_RESETN = 1'b1;
    tick();
    c = cyc;
    fire(1'b1, 1'b0);
    wait_cyc(c + 2);
    chk("fresh_sel0", 32'(boid_sel), 0);
    wait_cyc(c + 4);
    chk("fresh_sel1", 32'(boid_sel), 1);
    wait_idle();

    fire(1'b0, 1'b0);
    chk("gate_swap", 32'(disp_swap), 0);
    chk("gate_busy", 32'(busy), 0);
    chk("gate_overrun", 32'(overrun), 0);
    tick();
    chk("gate_busy2", 32'(busy), 0);
    fire(1'b1, 1'b0);
    wait_idle();

    force dut.frame_count = 16'hFFFF;
    tick();
    release dut.frame_count;
    fc_m = 16'hFFFF;
    fire(1'b1, 1'b0);
    wait_idle();

    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 12)) tick();
      if (cyc > busy_end) rand_pos();
      fire($urandom_range(0, 4) != 0, $urandom_range(0, 7) == 0);
    end
    wait_idle();
    chk("final_overrun", 32'(overrun), 32'(ov_m));
    chk("swq_empty", swq.size(), 0);
    chk("wrq_empty", wrq.size(), 0);
    chk("dnq_empty", dnq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
